// File: rtl/conv_pkg.sv
// Shared types and constants for the conv engine memory-side blocks.
// The arbiter state encoding and requester identifiers live here so that both sides agree on them.
package conv_pkg;

    localparam int ADDR_W = 28;
    localparam int LEN_W  = 6;

    localparam logic OWN_RD = 1'b0;
    localparam logic OWN_WR = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_XFER
    } arb_state_t;

endpackage

// File: rtl/conv_rr_pick.sv
// Two-way round-robin pick between the read and write requesters.
// On a tie the side that did not win last time is chosen; otherwise the lone requester wins.
module conv_rr_pick
    import conv_pkg::*;
(
    input  logic rd_req,
    input  logic wr_req,
    input  logic last,
    output logic sel
);

    always_comb begin
        sel = OWN_RD;
        if (rd_req && wr_req) begin
            sel = ~last;
        end else if (wr_req) begin
            sel = OWN_WR;
        end
    end

endmodule

// File: rtl/conv_mem_arb.sv
// Round-robin, non-preemptive arbiter for the single external memory port.
// It is shared by the conv read engine and the conv write engine, and it routes beats to and from the burst owner.
module conv_mem_arb
    import conv_pkg::arb_state_t, conv_pkg::ARB_IDLE, conv_pkg::ARB_CMD, conv_pkg::ARB_XFER,
           conv_pkg::OWN_RD, conv_pkg::OWN_WR;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int LEN_W  = conv_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic              wr_beat,
    output logic              wr_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    input  logic              mem_beat,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata
);

    arb_state_t       state;
    logic             owner;
    logic             last;
    logic             sel;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] last_idx;
    logic             busy;
    logic             in_xfer;

    conv_rr_pick u_pick (
        .rd_req (rd_req),
        .wr_req (wr_req),
        .last   (last),
        .sel    (sel)
    );

    // A latched len of 0 wraps to all-ones, which makes the 2**LEN_W-beat burst fall out naturally.
    assign last_idx = mem_cmd_len - LEN_W'(1);
    assign busy     = (state != ARB_IDLE);
    assign in_xfer  = (state == ARB_XFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB_IDLE;
            owner         <= OWN_RD;
            last          <= OWN_WR;
            beat_cnt      <= '0;
            rd_grant      <= 1'b0;
            wr_grant      <= 1'b0;
            rd_done       <= 1'b0;
            wr_done       <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_len   <= '0;
        end else begin
            rd_grant <= 1'b0;
            wr_grant <= 1'b0;
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (rd_req || wr_req) begin
                        owner         <= sel;
                        last          <= sel;
                        mem_cmd_we    <= (sel == OWN_WR);
                        mem_cmd_addr  <= (sel == OWN_WR) ? wr_addr : rd_addr;
                        mem_cmd_len   <= (sel == OWN_WR) ? wr_len : rd_len;
                        rd_grant      <= (sel == OWN_RD);
                        wr_grant      <= (sel == OWN_WR);
                        mem_cmd_valid <= 1'b1;
                        state         <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (mem_beat) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == last_idx) begin
                            rd_done <= (owner == OWN_RD);
                            wr_done <= (owner == OWN_WR);
                            state   <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Beat routing is combinational so the owner sees its strobe in the same cycle as mem_beat.
    assign rd_valid  = in_xfer && (owner == OWN_RD) && mem_beat;
    assign wr_beat   = in_xfer && (owner == OWN_WR) && mem_beat;
    assign rd_data   = (busy && owner == OWN_RD) ? mem_rdata : '0;
    assign mem_wdata = (busy && owner == OWN_WR) ? wr_data : '0;

endmodule

// File: tb/tb_conv_mem_arb.sv
// Bench for conv_mem_arb: table-driven single-requester bursts plus hand sequences for tie, reset and request-drop cases.
// Beat data is tracked through an expected-beat queue.
module tb_conv_mem_arb;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [LW-1:0] rd_len, wr_len;
    logic [DW-1:0] wr_data, mem_rdata;
    logic          rd_grant, rd_valid, rd_done;
    logic          wr_grant, wr_beat, wr_done;
    logic [DW-1:0] rd_data, mem_wdata;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_beat;
    logic [AW-1:0] mem_cmd_addr;
    logic [LW-1:0] mem_cmd_len;

    always #5 clk = ~clk;

    conv_mem_arb dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_grant      (rd_grant),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_done       (rd_done),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_data       (wr_data),
        .wr_grant      (wr_grant),
        .wr_beat       (wr_beat),
        .wr_done       (wr_done),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_beat      (mem_beat),
        .mem_rdata     (mem_rdata),
        .mem_wdata     (mem_wdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            rdy_dly;
        bit            pulse;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_len;
        int            exp_beats;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Every beat presented is matched against the queue: one expected entry means one routed strobe.
    always begin
        @(negedge clk);
        #2;
        if (mem_beat || rd_valid || wr_beat) begin
            if (exp_q.size() == 0) begin
                chk("stray_strobe", 64'({rd_valid, wr_beat}), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.we) begin
                    chk("wr_route", 64'({rd_valid, wr_beat}), 64'd1);
                    chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
                end else begin
                    chk("rd_route", 64'({rd_valid, wr_beat}), 64'd2);
                    chk("rd_data", 64'(rd_data), 64'(mon_e.data));
                end
            end
        end
    end

    task automatic expect_grant(input logic we, input int lat, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd_grant || wr_grant) && n < 8);
        if (!(rd_grant || wr_grant)) begin
            chk({tag, "_grant_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_grant_side"}, 64'({wr_grant, rd_grant}), we ? 64'd2 : 64'd1);
            chk({tag, "_grant_lat"}, 64'(n), 64'(lat));
        end
    endtask

    task automatic cmd_phase(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int rdy_dly, input bit pulse, input string tag);
        int unstable = 0;
        chk({tag, "_cmd_valid"}, 64'(mem_cmd_valid), 64'd1);
        chk({tag, "_cmd_we"}, 64'(mem_cmd_we), 64'(we));
        chk({tag, "_cmd_addr"}, 64'(mem_cmd_addr), 64'(addr));
        chk({tag, "_cmd_len"}, 64'(mem_cmd_len), 64'(len));
        for (int i = 0; i < rdy_dly; i++) begin
            mem_cmd_ready = 1'b0;
            mem_beat      = pulse;
            mem_rdata     = $urandom;
            wr_data       = $urandom;
            @(negedge clk);
            if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== we || mem_cmd_addr !== addr || mem_cmd_len !== len)
                unstable++;
        end
        chk({tag, "_cmd_stable"}, 64'(unstable), 64'd0);
        mem_beat      = 1'b0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        chk({tag, "_cmd_drop"}, 64'(mem_cmd_valid), 64'd0);
    endtask

    task automatic data_phase(input logic we, input int nbeats, input int clr_wr_at, input string tag);
        int    early = 0;
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            if (i == clr_wr_at) wr_req = 1'b0;
            mem_beat  = 1'b1;
            mem_rdata = $urandom;
            wr_data   = $urandom;
            b.we      = we;
            b.data    = we ? wr_data : mem_rdata;
            exp_q.push_back(b);
            @(negedge clk);
            if (i < nbeats - 1) begin
                if (rd_done || wr_done) early++;
            end else begin
                mem_beat = 1'b0;
                chk({tag, "_done"}, 64'({wr_done, rd_done}), we ? 64'd2 : 64'd1);
            end
        end
        chk({tag, "_early_done"}, 64'(early), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 28'h0000100, 6'd4, 0, 1'b0, 28'h0000100, 6'd4, 4};
        vecs[1] = '{1'b1, 28'hABCDEF0, 6'd3, 2, 1'b0, 28'hABCDEF0, 6'd3, 3};
        vecs[2] = '{1'b0, 28'hFFFFFFF, 6'd1, 0, 1'b0, 28'hFFFFFFF, 6'd1, 1};
        vecs[3] = '{1'b1, 28'h0000001, 6'd0, 0, 1'b0, 28'h0000001, 6'd0, 64};
        vecs[4] = '{1'b0, 28'h1234567, 6'd8, 5, 1'b1, 28'h1234567, 6'd8, 8};

        rst = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        wr_data = 32'hDEADBEEF; mem_rdata = 32'hCAFEF00D;
        mem_cmd_ready = 1'b0; mem_beat = 1'b0;
        repeat (3) @(negedge clk);
        mem_beat = 1'b1;
        #1;
        chk("rst_ctrl", 64'({rd_grant, rd_valid, rd_done, wr_grant, wr_beat, wr_done, mem_cmd_valid, mem_cmd_we}), 64'd0);
        chk("rst_addr", 64'(mem_cmd_addr), 64'd0);
        chk("rst_len", 64'(mem_cmd_len), 64'd0);
        chk("rst_data", 64'({rd_data, mem_wdata}), 64'd0);
        @(negedge clk);
        mem_beat = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (vecs[i].we) begin
                wr_req = 1'b1; wr_addr = vecs[i].addr; wr_len = vecs[i].len;
            end else begin
                rd_req = 1'b1; rd_addr = vecs[i].addr; rd_len = vecs[i].len;
            end
            expect_grant(vecs[i].we, 1, tag);
            rd_req = 1'b0; wr_req = 1'b0;
            rd_addr = ~vecs[i].addr; wr_addr = ~vecs[i].addr;
            rd_len = ~vecs[i].len; wr_len = ~vecs[i].len;
            cmd_phase(vecs[i].we, vecs[i].exp_addr, vecs[i].exp_len, vecs[i].rdy_dly, vecs[i].pulse, tag);
            data_phase(vecs[i].we, vecs[i].exp_beats, -1, tag);
            @(negedge clk);
        end

        // Simultaneous requests right after reset: read first, then strict alternation while both stay high.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_req = 1'b1; rd_addr = 28'h0000A00; rd_len = 6'd2;
        wr_req = 1'b1; wr_addr = 28'h0000B00; wr_len = 6'd3;
        expect_grant(1'b0, 1, "tie1");
        cmd_phase(1'b0, 28'h0000A00, 6'd2, 0, 1'b0, "tie1");
        data_phase(1'b0, 2, -1, "tie1");
        expect_grant(1'b1, 1, "tie2");
        cmd_phase(1'b1, 28'h0000B00, 6'd3, 1, 1'b0, "tie2");
        data_phase(1'b1, 3, -1, "tie2");
        expect_grant(1'b0, 1, "tie3");
        rd_req = 1'b0; wr_req = 1'b0;
        cmd_phase(1'b0, 28'h0000A00, 6'd2, 0, 1'b0, "tie3");
        data_phase(1'b0, 2, -1, "tie3");
        @(negedge clk);

        // Reset after 2 of 8 read beats, then a fresh write burst.
        rd_req = 1'b1; rd_addr = 28'h0000C00; rd_len = 6'd8;
        expect_grant(1'b0, 1, "rstx");
        rd_req = 1'b0;
        cmd_phase(1'b0, 28'h0000C00, 6'd8, 0, 1'b0, "rstx");
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            mem_beat  = 1'b1;
            mem_rdata = $urandom;
            b.we      = 1'b0;
            b.data    = mem_rdata;
            exp_q.push_back(b);
            @(negedge clk);
        end
        rst = 1'b1;
        mem_beat = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        #1;
        chk("rstx_ctrl", 64'({rd_grant, rd_valid, rd_done, wr_grant, wr_beat, wr_done, mem_cmd_valid, mem_cmd_we}), 64'd0);
        chk("rstx_cmd", 64'({mem_cmd_addr, mem_cmd_len}), 64'd0);
        chk("rstx_data", 64'({rd_data, mem_wdata}), 64'd0);
        @(negedge clk);
        mem_beat = 1'b0;
        rst = 1'b0;
        wr_req = 1'b1; wr_addr = 28'h0000D00; wr_len = 6'd3;
        expect_grant(1'b1, 1, "post");
        wr_req = 1'b0;
        cmd_phase(1'b1, 28'h0000D00, 6'd3, 0, 1'b0, "post");
        data_phase(1'b1, 3, -1, "post");
        @(negedge clk);

        // A write request that appears and vanishes during a read burst is never served.
        rd_req = 1'b1; rd_addr = 28'h0000E00; rd_len = 6'd4;
        expect_grant(1'b0, 1, "drop");
        rd_req = 1'b0;
        wr_req = 1'b1; wr_addr = 28'h0000F00; wr_len = 6'd2;
        cmd_phase(1'b0, 28'h0000E00, 6'd4, 1, 1'b0, "drop");
        data_phase(1'b0, 4, 2, "drop");
        begin
            int bad = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rd_grant || wr_grant || mem_cmd_valid) bad++;
            end
            chk("drop_idle", 64'(bad), 64'd0);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
